// File: rtl/idct1d_serial_if.sv
// Stream bundle for the serial 8-point IDCT: coefficient input side, sample output side.
interface idct1d_serial_if #(
    parameter int N = 16
);
    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] data_in;
    logic                out_valid;
    logic                out_ready;
    logic signed [N-1:0] data_out;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out
    );
endinterface

// File: rtl/idct1d_serial.sv
// 8-point 1-D inverse DCT: loads X[0..7], runs 64 MACs on one shared multiplier,
// then drains x[0..7] with valid/ready backpressure.
//
// state   | meaning
// LOAD    | accepting coefficients into ibuf, icnt counts accepts
// COMPUTE | 64 MAC cycles (n outer, k inner) plus one trailing write-back
// DRAIN   | presenting obuf[ocnt] until eight output handshakes complete
module idct1d_serial #(
    parameter int N      = 16,
    parameter int COEF_W = 16,
    parameter int FRAC   = 14
) (
    input  logic             clk,
    input  logic             reset,
    idct1d_serial_if.slave   bus,
    output logic             busy
);
    localparam int ACC_W = N + COEF_W + 3;
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC - 1);
    localparam logic signed [N-1:0]     SMAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0]     SMIN = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic signed [N-1:0]     ibuf [8];
    logic signed [N-1:0]     obuf [8];
    logic [2:0]              icnt_q;
    logic [2:0]              ocnt_q;
    logic [6:0]              mac_cnt_q;
    logic signed [ACC_W-1:0] acc_q;

    logic [2:0]                n_idx;
    logic [2:0]                k_idx;
    logic                      in_fire;
    logic                      out_fire;
    logic signed [N+COEF_W-1:0] prod;
    logic signed [ACC_W-1:0]   rnd;
    logic signed [N-1:0]       sat;

    // Cosine ROM folded onto one quarter-wave table of 8192*cos(j*pi/16).
    function automatic logic signed [COEF_W-1:0] rom_coef(input logic [2:0] n, input logic [2:0] k);
        logic [6:0]               t;
        logic [4:0]               m;
        logic [3:0]               j;
        logic                     neg;
        logic signed [COEF_W-1:0] mag;
        t   = {3'b000, n, 1'b1} * {4'b0000, k};
        m   = t[4:0];
        if (m > 5'd16) m = 5'd0 - m;
        neg = (m > 5'd8);
        j   = neg ? 4'(5'd16 - m) : m[3:0];
        case (j)
            4'd0:    mag = COEF_W'(8192);
            4'd1:    mag = COEF_W'(8035);
            4'd2:    mag = COEF_W'(7568);
            4'd3:    mag = COEF_W'(6811);
            4'd4:    mag = COEF_W'(5793);
            4'd5:    mag = COEF_W'(4551);
            4'd6:    mag = COEF_W'(3135);
            4'd7:    mag = COEF_W'(1598);
            default: mag = '0;
        endcase
        if (k == 3'd0) begin
            mag = COEF_W'(5793);
            neg = 1'b0;
        end
        return neg ? -mag : mag;
    endfunction

    assign n_idx    = mac_cnt_q[5:3];
    assign k_idx    = mac_cnt_q[2:0];
    assign in_fire  = (state_q == LOAD) && bus.in_valid;
    assign out_fire = (state_q == DRAIN) && bus.out_ready;
    assign busy     = (state_q != LOAD) || (icnt_q != 3'd0);
    assign prod     = ibuf[k_idx] * rom_coef(n_idx, k_idx);

    always_comb begin
        rnd = (acc_q + HALF) >>> FRAC;
        if (rnd > ACC_W'(SMAX))
            sat = SMAX;
        else if (rnd < ACC_W'(SMIN))
            sat = SMIN;
        else
            sat = rnd[N-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= LOAD;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.data_out  = '0;
        case (state_q)
            LOAD: begin
                bus.in_ready = 1'b1;
                if (in_fire && icnt_q == 3'd7) state_d = COMPUTE;
            end
            COMPUTE: begin
                if (mac_cnt_q == 7'd64) state_d = DRAIN;
            end
            DRAIN: begin
                bus.out_valid = 1'b1;
                bus.data_out  = obuf[ocnt_q];
                if (out_fire && ocnt_q == 3'd7) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                ibuf[i] <= '0;
                obuf[i] <= '0;
            end
            icnt_q    <= '0;
            ocnt_q    <= '0;
            mac_cnt_q <= '0;
            acc_q     <= '0;
        end else begin
            if (in_fire) begin
                ibuf[icnt_q] <= bus.data_in;
                icnt_q       <= icnt_q + 3'd1;
            end
            if (state_q == COMPUTE) begin
                if (k_idx == 3'd0)
                    acc_q <= ACC_W'(prod);
                else
                    acc_q <= acc_q + ACC_W'(prod);
                // acc completes row n-1 while row n's first product is being loaded
                if (mac_cnt_q != 7'd0 && k_idx == 3'd0)
                    obuf[n_idx - 3'd1] <= sat;
                mac_cnt_q <= (mac_cnt_q == 7'd64) ? 7'd0 : mac_cnt_q + 7'd1;
            end
            if (out_fire)
                ocnt_q <= ocnt_q + 3'd1;
        end
    end
endmodule
